// File: rtl/ksa_share_ctrl.sv
// Round-robin front end that time-shares one combinational Kogge-Stone adder between two
// requesters. It registers the adder operands, captures the result and holds it behind valid/ready.
module ksa_share_ctrl #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic [WIDTH-1:0] res_s,
  output logic             res_co,
  output logic             res_ov,
  output logic             res_id,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic             any_req;
  logic             win;
  logic             do_latch;
  logic             sub_w;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;

  always_comb begin
    any_req  = req0 | req1;
    // A lone requester always wins; the pointer only breaks ties.
    win      = (req0 & req1) ? ptr_q : req1;
    a_w      = win ? a1 : a0;
    b_w      = win ? b1 : b0;
    sub_w    = win ? sub1 : sub0;
    do_latch = any_req & ((state_q == StIdle) | ((state_q == StHold) & res_ready));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_ci    <= 1'b0;
      res_s     <= '0;
      res_co    <= 1'b0;
      res_ov    <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (do_latch) begin
        // Subtraction as A + ~B + 1, so the adder itself never needs a mode input.
        add_a   <= a_w;
        add_b   <= sub_w ? ~b_w : b_w;
        add_ci  <= sub_w;
        owner_q <= win;
        ptr_q   <= ~win;
        gnt0    <= ~win;
        gnt1    <= win;
      end
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StExec;
            busy    <= 1'b1;
          end
        end
        StExec: begin
          res_s     <= add_s;
          res_co    <= add_co;
          res_id    <= owner_q;
          res_ov    <= (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_s[WIDTH-1] != add_a[WIDTH-1]);
          res_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (any_req) begin
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_share_ctrl.sv
// Bench for ksa_share_ctrl: a behavioural adder, a cycle-level reference model feeding a
// result scoreboard, and directed scenarios for add/sub, fairness, backpressure and reset.
module tb_ksa_share_ctrl;
  localparam int unsigned W = 24;

  logic         clk;
  logic         rst;
  logic         req0, req1, sub0, sub1, res_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, add_ci, add_co, res_co, res_ov, res_id, res_valid, busy;
  logic [W-1:0] add_a, add_b, add_s, res_s;
  logic [W:0]   sum_full;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         id;
  } res_t;

  res_t q[$];

  ksa_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sub0(sub0), .sub1(sub1), .gnt0(gnt0), .gnt1(gnt1), .add_a(add_a), .add_b(add_b),
    .add_ci(add_ci), .add_s(add_s), .add_co(add_co), .res_s(res_s), .res_co(res_co),
    .res_ov(res_ov), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  // Stand-in for the shared Kogge-Stone adder.
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  assign add_s    = sum_full[W-1:0];
  assign add_co   = sum_full[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                input logic id);
    res_t       r;
    logic [W:0] full;
    full = sub ? ({1'b0, a} - {1'b0, b} + (1 << W)) : ({1'b0, a} + {1'b0, b});
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = sub ? ((a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]))
               : ((a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]));
    r.id = id;
    return r;
  endfunction

  // Reference model: 0 idle, 1 exec, 2 hold.
  int   m_state;
  logic m_ptr, m_gnt0, m_gnt1, m_valid, m_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0;
      m_ptr   <= 1'b0;
      m_gnt0  <= 1'b0;
      m_gnt1  <= 1'b0;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      q.delete();
    end else begin
      logic any, w, latch;
      any   = req0 | req1;
      w     = (req0 & req1) ? m_ptr : req1;
      latch = any && (m_state == 0 || (m_state == 2 && res_ready));
      m_gnt0 <= 1'b0;
      m_gnt1 <= 1'b0;
      if (m_state == 0) begin
        if (any) begin
          m_state <= 1;
          m_busy  <= 1'b1;
        end
      end else if (m_state == 1) begin
        m_state <= 2;
        m_valid <= 1'b1;
      end else if (res_ready) begin
        m_valid <= 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        m_state <= any ? 1 : 0;
        m_busy  <= any;
      end
      if (latch) begin
        m_ptr  <= ~w;
        m_gnt0 <= ~w;
        m_gnt1 <= w;
        q.push_back(w ? calc(a1, b1, sub1, 1'b1) : calc(a0, b0, sub0, 1'b0));
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt0", {31'd0, gnt0}, {31'd0, m_gnt0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, m_gnt1});
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (m_valid) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        chk("sb_res_s", {8'd0, res_s}, {8'd0, q[0].s});
        chk("sb_res_co", {31'd0, res_co}, {31'd0, q[0].co});
        chk("sb_res_ov", {31'd0, res_ov}, {31'd0, q[0].ov});
        chk("sb_res_id", {31'd0, res_id}, {31'd0, q[0].id});
      end
    end
  end

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    bit seen;
    @(negedge clk);
    #1;
    if (id) begin
      a1 = a; b1 = b; sub1 = sub; req1 = 1'b1;
    end else begin
      a0 = a; b0 = b; sub0 = sub; req0 = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = id ? gnt1 : gnt0;
    end
    if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    if (!seen) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int first;
    bit seen;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      req0 = i[0]; req1 = ~i[0]; res_ready = i[1]; a0 = 24'h123456; b1 = 24'h654321;
    end
    @(negedge clk);
    chk("rst_add_a", {8'd0, add_a}, 32'd0);
    chk("rst_add_b", {8'd0, add_b}, 32'd0);
    chk("rst_add_ci", {31'd0, add_ci}, 32'd0);
    chk("rst_res_s", {8'd0, res_s}, 32'd0);
    chk("rst_res_flags", {28'd0, res_co, res_ov, res_id, res_valid}, 32'd0);
    #1;
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1; rst = 1'b1;

    // Contention: both requesters held, grants must alternate starting with 0.
    @(negedge clk);
    #1;
    a0 = 24'd1; b0 = 24'd2; sub0 = 1'b0; a1 = 24'd10; b1 = 24'd3; sub1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (first < 0 && (gnt0 || gnt1)) first = gnt1 ? 1 : 0;
    end
    chk("first_gnt", first, 32'd0);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);

    // Single add with signed overflow.
    issue(1'b0, 24'h7FFFFF, 24'h000001, 1'b0);
    wait_valid();
    chk("add_s", {8'd0, res_s}, 32'h800000);
    chk("add_co_ov_id", {29'd0, res_co, res_ov, res_id}, 32'b010);

    // Subtract with and without borrow.
    issue(1'b1, 24'h000005, 24'h000007, 1'b1);
    wait_valid();
    chk("sub_borrow_s", {8'd0, res_s}, 32'hFFFFFE);
    chk("sub_borrow_flags", {29'd0, res_co, res_ov, res_id}, 32'b001);
    issue(1'b1, 24'h000007, 24'h000005, 1'b1);
    wait_valid();
    chk("sub_s", {8'd0, res_s}, 32'h000002);
    chk("sub_flags", {29'd0, res_co, res_ov, res_id}, 32'b101);

    // Backpressure with requester 1 already queueing its next operation.
    @(negedge clk);
    #1;
    res_ready = 1'b0; a1 = 24'h000007; b1 = 24'h000005; sub1 = 1'b1; req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = gnt1;
    end
    if (!seen) chk("bp_gnt_timeout", 32'd0, 32'd1);
    #1;
    a1 = 24'h000100; b1 = 24'h000023; sub1 = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res_s", {8'd0, res_s}, 32'h000002);
      chk("bp_res_id", {31'd0, res_id}, 32'd1);
      chk("bp_no_gnt", {31'd0, gnt1}, 32'd0);
    end
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt1", {31'd0, gnt1}, 32'd1);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_next_s", {8'd0, res_s}, 32'h000123);
    repeat (3) @(negedge clk);

    // Reset during EXEC discards the in-flight result.
    @(negedge clk);
    #1;
    a0 = 24'h000AAA; b0 = 24'h000555; sub0 = 1'b0; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = gnt0;
    end
    if (!seen) chk("rx_gnt_timeout", 32'd0, 32'd1);
    #1;
    rst = 1'b0; req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_no_valid", {31'd0, res_valid}, 32'd0);
    end
    #1;
    rst = 1'b1;
    issue(1'b0, 24'h000010, 24'h000020, 1'b1);
    wait_valid();
    chk("rx_after_s", {8'd0, res_s}, 32'hFFFFF0);
    chk("rx_after_flags", {29'd0, res_co, res_ov, res_id}, 32'b000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
